// File: rtl/nt_obs_capture.sv
// Windowed observation of an Nt-node output: MISR signature, ones/toggle counts, rare-activation flag.
// Build option NT_OBS_TOGGLE_CNT_EN adds the toggle counter; without it toggle_cnt reads 0.
module nt_obs_capture #(
  parameter int unsigned        SIG_W       = 16,
  parameter logic [SIG_W-1:0]   POLY        = 16'hB400,
  parameter logic [SIG_W-1:0]   SEED        = 16'h0000,
  parameter int unsigned        WIN_LEN     = 256,
  parameter int unsigned        RARE_THRESH = 4,
  localparam int unsigned       CW          = $clog2(WIN_LEN + 1)
) (
  input  logic             I1294_clk,
  input  logic             I1301_rst,
  input  logic             obs_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig_out,
  output logic [CW-1:0]    ones_cnt,
  output logic [CW-1:0]    toggle_cnt,
  output logic             rare_flag
);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e           state;
  logic [CW-1:0]    sample_cnt;
  logic [SIG_W-1:0] sig_next;
  logic [CW-1:0]    ones_next;
  logic [CW-1:0]    zeros_next;
  logic [CW-1:0]    min_next;
  logic             rare_next;
  logic             last_sample;

  always_comb begin
    sig_next    = {obs_in, sig_out[SIG_W-1:1]} ^ (sig_out[0] ? POLY : '0);
    ones_next   = ones_cnt + CW'(obs_in);
    zeros_next  = CW'(WIN_LEN) - ones_next;
    min_next    = (ones_next < zeros_next) ? ones_next : zeros_next;
    rare_next   = (32'(min_next) <= RARE_THRESH);
    last_sample = (sample_cnt == CW'(WIN_LEN - 1));
  end

  always_ff @(posedge I1294_clk or posedge I1301_rst) begin
    if (I1301_rst) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      rare_flag  <= 1'b0;
      sig_out    <= '0;
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StCapture;
            busy       <= 1'b1;
            rare_flag  <= 1'b0;
            sig_out    <= SEED;
            ones_cnt   <= '0;
            sample_cnt <= '0;
          end
        end
        StCapture: begin
          sig_out    <= sig_next;
          ones_cnt   <= ones_next;
          sample_cnt <= sample_cnt + CW'(1);
          // Flag is taken from the count that includes the final sample.
          if (last_sample) begin
            state     <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            rare_flag <= rare_next;
          end
        end
        StDone: begin
          if (ack) begin
            state <= StIdle;
            done  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef NT_OBS_TOGGLE_CNT_EN
  logic prev;

  always_ff @(posedge I1294_clk or posedge I1301_rst) begin
    if (I1301_rst) begin
      prev       <= 1'b0;
      toggle_cnt <= '0;
    end else if (state == StIdle && start) begin
      prev       <= obs_in;
      toggle_cnt <= '0;
    end else if (state == StCapture) begin
      prev       <= obs_in;
      toggle_cnt <= toggle_cnt + CW'(obs_in != prev);
    end
  end
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_nt_obs_capture.sv
// Scoreboard bench for nt_obs_capture with an 8-sample window; expectations queued at start,
// checked by a monitor when done rises.
module tb_nt_obs_capture;
  localparam int unsigned WinLen = 8;
  localparam int unsigned Cw     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          obs_in = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          busy, done, rare_flag;
  logic [15:0]   sig_out;
  logic [Cw-1:0] ones_cnt, toggle_cnt;

  nt_obs_capture #(
    .SIG_W      (16),
    .POLY       (16'hB400),
    .SEED       (16'h0000),
    .WIN_LEN    (WinLen),
    .RARE_THRESH(2)
  ) dut (
    .I1294_clk (clk),
    .I1301_rst (rst),
    .obs_in    (obs_in),
    .start     (start),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .sig_out   (sig_out),
    .ones_cnt  (ones_cnt),
    .toggle_cnt(toggle_cnt),
    .rare_flag (rare_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig;
    int          ones;
    int          tog;
    logic        rare;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

`ifdef NT_OBS_TOGGLE_CNT_EN
  localparam int AltToggles = 8;
`else
  localparam int AltToggles = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising done is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no window", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_sig"},   sig_out,    e.sig);
        check({e.name, "_ones"},  ones_cnt,   e.ones);
        check({e.name, "_tog"},   toggle_cnt, e.tog);
        check({e.name, "_rare"},  rare_flag,  e.rare);
        check({e.name, "_cycle"}, cyc,        e.cyc);
        check({e.name, "_busy"},  busy,       0);
      end
    end
    done_prev = done;
  end

  // bits[0] is the first sample; mid_start < 0 means no stray start pulse.
  task automatic run_window(input string name, input logic first, input logic [7:0] bits,
                            input logic [15:0] esig, input int eones, input int etog,
                            input logic erare, input int mid_start);
    exp_t x;
    obs_in = first;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    x.sig = esig; x.ones = eones; x.tog = etog; x.rare = erare;
    x.cyc = cyc + WinLen; x.name = name;
    exp_q.push_back(x);
    check({name, "_busy_rise"}, busy, 1);
    for (int i = 0; i < WinLen; i++) begin
      obs_in = bits[i];
      start  = (i == mid_start);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic finish_window();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", sig_out, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_tog", toggle_cnt, 0);
    check("rst_rare", rare_flag, 0);
    rst = 1'b0;
    tick();

    run_window("zeros", 1'b0, 8'h00, 16'h0000, 0, 0, 1'b1, -1);
    finish_window();
    run_window("ones", 1'b1, 8'hFF, 16'hFF00, 8, 0, 1'b1, -1);
    finish_window();
    run_window("alt", 1'b0, 8'h55, 16'h5500, 4, AltToggles, 1'b0, -1);
    finish_window();

    // Stray start mid-capture must not disturb timing or results.
    run_window("hs", 1'b1, 8'hFF, 16'hFF00, 8, 0, 1'b1, 3);
    tick();
    tick();
    check("hs_hold_done", done, 1);
    check("hs_hold_sig", sig_out, 16'hFF00);
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("hs_ackstart_done", done, 0);
    check("hs_ackstart_busy", busy, 0);
    tick();
    tick();
    check("hs_no_restart_busy", busy, 0);
    check("hs_idle_sig_held", sig_out, 16'hFF00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("hs_idle_ack_done", done, 0);
    check("hs_idle_ack_busy", busy, 0);
    check("hs_idle_ack_ones", ones_cnt, 8);

    // Asynchronous reset after four samples of a window.
    obs_in = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    check("pre_rst_sig", sig_out, 16'hF000);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sig", sig_out, 0);
    check("mid_rst_ones", ones_cnt, 0);
    check("mid_rst_tog", toggle_cnt, 0);
    check("mid_rst_rare", rare_flag, 0);
    tick();
    rst = 1'b0;
    tick();
    run_window("post_rst", 1'b0, 8'h00, 16'h0000, 0, 0, 1'b1, -1);
    finish_window();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d windows without done, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
